// File: rtl/softmax_sum_ctrl_16_pkg.sv
// Shared definitions for the softmax sum controller: FSM encoding and
// default sizing of the exp datapath.
package softmax_sum_ctrl_16_pkg;

  localparam int DEF_DATA_W  = 16;
  localparam int DEF_MAX_LEN = 64;
  localparam int DEF_LEN_W   = 7;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_CLEAR    = 3'd1,
    ST_ACCUM    = 3'd2,
    ST_FLUSH    = 3'd3,
    ST_WAIT_SUM = 3'd4,
    ST_NORM     = 3'd5,
    ST_DONE     = 3'd6
  } state_t;

  function automatic logic is_busy(input state_t s);
    return s != ST_IDLE;
  endfunction

endpackage

// File: rtl/softmax_sum_ctrl_16_if.sv
// Handshake bundle between the softmax sum controller and its exp unit,
// exponent-sum adder and divider.
interface softmax_sum_ctrl_16_if #(
  parameter int DATA_W = softmax_sum_ctrl_16_pkg::DEF_DATA_W,
  parameter int LEN_W  = softmax_sum_ctrl_16_pkg::DEF_LEN_W
);
  logic              start_i;
  logic [LEN_W-1:0]  len_i;
  logic [DATA_W-1:0] exp_data_i;
  logic              exp_valid_i;
  logic              exp_ready_o;
  logic              adder_clear_o;
  logic [DATA_W-1:0] adder_data_o;
  logic              adder_valid_o;
  logic              exp_done_o;
  logic [DATA_W-1:0] sum_i;
  logic              sum_valid_i;
  logic [DATA_W-1:0] div_num_o;
  logic [DATA_W-1:0] div_den_o;
  logic              div_valid_o;
  logic              div_ready_i;
  logic              busy_o;
  logic              done_o;
  logic              err_o;

  // master is the controller's view; slave is the surrounding datapath
  modport master (
    input  start_i, len_i, exp_data_i, exp_valid_i, sum_i, sum_valid_i, div_ready_i,
    output exp_ready_o, adder_clear_o, adder_data_o, adder_valid_o, exp_done_o,
           div_num_o, div_den_o, div_valid_o, busy_o, done_o, err_o
  );

  modport slave (
    output start_i, len_i, exp_data_i, exp_valid_i, sum_i, sum_valid_i, div_ready_i,
    input  exp_ready_o, adder_clear_o, adder_data_o, adder_valid_o, exp_done_o,
           div_num_o, div_den_o, div_valid_o, busy_o, done_o, err_o
  );
endinterface

// File: rtl/softmax_vec_buf.sv
// Register buffer holding one softmax vector: synchronous write while the
// exp values stream in, combinational read while they are replayed.
module softmax_vec_buf #(
  parameter int DATA_W = 16,
  parameter int DEPTH  = 64,
  parameter int ADDR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic              clock_i,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [DATA_W-1:0] rd_data
);

  logic [DATA_W-1:0] mem_reg [DEPTH];

  always_ff @(posedge clock_i) begin
    if (wr_en) begin
      mem_reg[wr_addr] <= wr_data;
    end
  end

  assign rd_data = mem_reg[rd_addr];

endmodule

// File: rtl/softmax_sum_ctrl_16.sv
// Sequences one softmax vector: streams exp values into the sum adder while
// buffering them, then replays them with the latched sum to the divider.
module softmax_sum_ctrl_16
  import softmax_sum_ctrl_16_pkg::*;
#(
  parameter int DATA_W  = DEF_DATA_W,
  parameter int MAX_LEN = DEF_MAX_LEN,
  parameter int LEN_W   = DEF_LEN_W
) (
  input logic                   clock_i,
  input logic                   reset_i,
  softmax_sum_ctrl_16_if.master bus
);

  localparam int ADDR_W = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
  localparam logic [LEN_W-1:0] MAX_LEN_L = LEN_W'(MAX_LEN);
  localparam logic [LEN_W-1:0] ONE_L     = LEN_W'(1);

  state_t            state_reg;
  state_t            state_next;
  logic [LEN_W-1:0]  len_reg;
  logic [LEN_W-1:0]  in_cnt_reg;
  logic [LEN_W-1:0]  out_cnt_reg;
  logic [DATA_W-1:0] sum_reg;
  logic [DATA_W-1:0] adder_data_reg;
  logic              adder_valid_reg;
  logic              exp_done_reg;
  logic              err_reg;

  logic              len_legal;
  logic              start_ok;
  logic              start_bad;
  logic              exp_fire;
  logic              div_fire;
  logic              in_last;
  logic              out_last;
  logic              div_active;
  logic [DATA_W-1:0] buf_rd_data;

  assign len_legal  = (bus.len_i != '0) && (bus.len_i <= MAX_LEN_L);
  assign start_ok   = (state_reg == ST_IDLE) && bus.start_i && len_legal;
  assign start_bad  = (state_reg == ST_IDLE) && bus.start_i && !len_legal;

  assign bus.exp_ready_o = (state_reg == ST_ACCUM) && (in_cnt_reg < len_reg);
  assign exp_fire        = bus.exp_valid_i && bus.exp_ready_o;
  assign in_last         = (in_cnt_reg == len_reg - ONE_L);

  // NORM is only entered with out_cnt below len, so valid is a pure state decode
  assign div_active      = (state_reg == ST_NORM);
  assign div_fire        = div_active && bus.div_ready_i;
  assign out_last        = (out_cnt_reg == len_reg - ONE_L);

  assign bus.adder_clear_o = (state_reg == ST_CLEAR);
  assign bus.adder_data_o  = adder_data_reg;
  assign bus.adder_valid_o = adder_valid_reg;
  assign bus.exp_done_o    = exp_done_reg;
  assign bus.div_valid_o   = div_active;
  assign bus.div_num_o     = div_active ? buf_rd_data : '0;
  assign bus.div_den_o     = div_active ? sum_reg : '0;
  assign bus.busy_o        = is_busy(state_reg);
  assign bus.done_o        = (state_reg == ST_DONE);
  assign bus.err_o         = err_reg;

  always_comb begin
    state_next = state_reg;
    unique case (state_reg)
      ST_IDLE:     if (start_ok) state_next = ST_CLEAR;
      ST_CLEAR:    state_next = ST_ACCUM;
      ST_ACCUM:    if (exp_fire && in_last) state_next = ST_FLUSH;
      ST_FLUSH:    state_next = ST_WAIT_SUM;
      ST_WAIT_SUM: if (bus.sum_valid_i) state_next = ST_NORM;
      ST_NORM:     if (div_fire && out_last) state_next = ST_DONE;
      ST_DONE:     state_next = ST_IDLE;
      default:     state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      state_reg <= ST_IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Counters, latched length/sum and the registered adder beat
  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      len_reg         <= '0;
      in_cnt_reg      <= '0;
      out_cnt_reg     <= '0;
      sum_reg         <= '0;
      adder_data_reg  <= '0;
      adder_valid_reg <= 1'b0;
      exp_done_reg    <= 1'b0;
      err_reg         <= 1'b0;
    end else begin
      err_reg         <= start_bad;
      exp_done_reg    <= (state_reg == ST_FLUSH);
      adder_valid_reg <= exp_fire;
      if (start_ok) begin
        len_reg     <= bus.len_i;
        in_cnt_reg  <= '0;
        out_cnt_reg <= '0;
      end
      if (exp_fire) begin
        adder_data_reg <= bus.exp_data_i;
        in_cnt_reg     <= in_cnt_reg + ONE_L;
      end
      if ((state_reg == ST_WAIT_SUM) && bus.sum_valid_i) begin
        sum_reg <= bus.sum_i;
      end
      if (div_fire) begin
        out_cnt_reg <= out_cnt_reg + ONE_L;
      end
    end
  end

  softmax_vec_buf #(
    .DATA_W (DATA_W),
    .DEPTH  (MAX_LEN),
    .ADDR_W (ADDR_W)
  ) u_buf (
    .clock_i (clock_i),
    .wr_en   (exp_fire),
    .wr_addr (in_cnt_reg[ADDR_W-1:0]),
    .wr_data (bus.exp_data_i),
    .rd_addr (out_cnt_reg[ADDR_W-1:0]),
    .rd_data (buf_rd_data)
  );

endmodule

// File: tb/tb_softmax_sum_ctrl_16.sv
// Self-checking bench for softmax_sum_ctrl_16: a summing adder model closes the
// loop, and each scenario compares observed beats against the vector it sent.
module tb_softmax_sum_ctrl_16;

  localparam int DATA_W  = 16;
  localparam int MAX_LEN = 64;
  localparam int LEN_W   = 7;
  localparam int BUDGET  = 2000;

  logic clock_i = 1'b0;
  logic reset_i = 1'b1;
  int   checks  = 0;
  int   errors  = 0;
  int   cyc     = 0;

  always #5 clock_i = ~clock_i;
  always @(posedge clock_i) cyc <= cyc + 1;

  softmax_sum_ctrl_16_if #(.DATA_W(DATA_W), .LEN_W(LEN_W)) bus ();

  softmax_sum_ctrl_16 #(
    .DATA_W  (DATA_W),
    .MAX_LEN (MAX_LEN),
    .LEN_W   (LEN_W)
  ) dut (
    .clock_i (clock_i),
    .reset_i (reset_i),
    .bus     (bus)
  );

  // Adder model: sums adder beats, raises a level valid sum_delay cycles after exp_done
  logic [15:0] add_acc;
  bit          add_armed;
  int          add_wait;
  int          sum_delay;

  always @(posedge clock_i) begin
    if (reset_i || bus.adder_clear_o) begin
      add_acc   <= '0;
      add_armed <= 1'b0;
      add_wait  <= 0;
    end else begin
      if (bus.adder_valid_o) add_acc <= add_acc + bus.adder_data_o;
      if (bus.exp_done_o) begin
        add_armed <= 1'b1;
        add_wait  <= sum_delay;
      end else if (add_armed && add_wait > 0) begin
        add_wait <= add_wait - 1;
      end
    end
  end

  assign bus.sum_i       = add_acc;
  assign bus.sum_valid_i = add_armed && (add_wait == 0);

  // Monitor
  logic [15:0] vec [MAX_LEN];
  logic [15:0] adder_q [$];
  logic [15:0] num_q [$];
  logic [15:0] den_q [$];
  int exp_done_cnt, exp_done_cyc, last_acc_cyc, done_cnt, div_at_done;
  int err_cnt, err_cyc, clear_cnt, busy_cnt, stall_err, stall_cyc;
  bit prev_stall;
  logic [15:0] prev_num, prev_den;

  always @(negedge clock_i) begin
    if (bus.adder_valid_o) adder_q.push_back(bus.adder_data_o);
    if (bus.exp_valid_i && bus.exp_ready_o) last_acc_cyc = cyc;
    if (bus.exp_done_o) begin
      exp_done_cnt++;
      exp_done_cyc = cyc;
    end
    if (prev_stall && (!bus.div_valid_o || bus.div_num_o !== prev_num || bus.div_den_o !== prev_den))
      stall_err++;
    prev_stall = bus.div_valid_o && !bus.div_ready_i;
    prev_num   = bus.div_num_o;
    prev_den   = bus.div_den_o;
    if (prev_stall) stall_cyc++;
    if (bus.div_valid_o && bus.div_ready_i) begin
      num_q.push_back(bus.div_num_o);
      den_q.push_back(bus.div_den_o);
    end
    if (bus.done_o) begin
      done_cnt++;
      div_at_done = num_q.size();
    end
    if (bus.err_o) begin
      err_cnt++;
      err_cyc = cyc;
    end
    if (bus.adder_clear_o) clear_cnt++;
    if (bus.busy_o) busy_cnt++;
  end

  task automatic clear_stats();
    adder_q.delete();
    num_q.delete();
    den_q.delete();
    exp_done_cnt = 0; exp_done_cyc = -1; last_acc_cyc = -100; done_cnt = 0; div_at_done = -1;
    err_cnt = 0; err_cyc = -1; clear_cnt = 0; busy_cnt = 0; stall_err = 0; stall_cyc = 0;
  endtask

  // Reference sum: plain modular addition of the vector sent
  function automatic logic [15:0] model_sum(input int len);
    logic [15:0] s = '0;
    for (int i = 0; i < len; i++) s = s + vec[i];
    return s;
  endfunction

  function automatic logic [55:0] all_outputs();
    return {bus.exp_ready_o, bus.adder_clear_o, bus.adder_data_o, bus.adder_valid_o,
            bus.exp_done_o, bus.div_num_o, bus.div_den_o, bus.div_valid_o,
            bus.busy_o, bus.done_o, bus.err_o};
  endfunction

  // Drives one vector from vec[] to completion; called at posedge+1
  task automatic run_vector(input int len, input bit gaps, input int stall_beat,
                            input int stall_len, input bit ign, output bit timeout);
    int idx = 0, div_cnt = 0, stall_ctr = 0, n = 0;
    bit fin = 0, norm_seen = 0, ign_sent = 0;
    bus.start_i = 1'b1;
    bus.len_i   = LEN_W'(len);
    @(posedge clock_i); #1;
    bus.start_i = 1'b0;
    while (!fin && n < BUDGET) begin
      bus.exp_valid_i = (idx < len) ? (!gaps || (n % 2 == 0)) : ign;
      bus.exp_data_i  = (idx < len) ? vec[idx] : 16'hDEAD;
      bus.div_ready_i = !(div_cnt == stall_beat && stall_ctr < stall_len);
      bus.start_i     = ign && norm_seen && !ign_sent;
      if (bus.start_i) bus.len_i = LEN_W'(3);
      @(negedge clock_i);
      if (bus.exp_valid_i && bus.exp_ready_o) idx++;
      if (bus.div_valid_o) begin
        norm_seen = 1;
        if (bus.div_ready_i) div_cnt++;
        else stall_ctr++;
      end
      if (bus.start_i) ign_sent = 1;
      if (bus.done_o) fin = 1;
      @(posedge clock_i); #1;
      n++;
    end
    bus.exp_valid_i = 1'b0;
    bus.div_ready_i = 1'b0;
    bus.start_i     = 1'b0;
    timeout = !fin;
    $display("vector len=%0d accepted=%0d div_beats=%0d cycles=%0d sum=%h", len, idx, div_cnt, n, model_sum(len));
  endtask

  task automatic test_reset();
    reset_i = 1'b1;
    repeat (2) @(posedge clock_i);
    @(negedge clock_i);
    checks++;
    if (all_outputs() !== '0) begin
      errors++; $display("FAIL reset_outputs got=%h want=0", all_outputs());
    end
    @(posedge clock_i); #1;
    reset_i = 1'b0;
    @(negedge clock_i);
    checks++;
    if (all_outputs() !== '0) begin
      errors++; $display("FAIL idle_outputs got=%h want=0", all_outputs());
    end
    @(posedge clock_i); #1;
  endtask

  task automatic test_basic();
    bit to;
    clear_stats();
    for (int i = 0; i < 4; i++) vec[i] = 16'((i + 1) * 256);
    sum_delay = 0;
    run_vector(4, 1'b0, -1, 0, 1'b0, to);
    checks++; if (to) begin errors++; $display("FAIL basic_timeout got=timeout want=done"); end
    checks++; if (adder_q.size() !== 4) begin errors++; $display("FAIL basic_adder_beats got=%0d want=4", adder_q.size()); end
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (i >= adder_q.size() || adder_q[i] !== vec[i]) begin
        errors++; $display("FAIL basic_adder_data[%0d] got=%h want=%h", i, (i < adder_q.size()) ? adder_q[i] : 16'hxxxx, vec[i]);
      end
    end
    checks++; if (exp_done_cnt !== 1) begin errors++; $display("FAIL basic_exp_done_count got=%0d want=1", exp_done_cnt); end
    checks++; if (exp_done_cyc !== last_acc_cyc + 2) begin errors++; $display("FAIL basic_exp_done_latency got=%0d want=%0d", exp_done_cyc - last_acc_cyc, 2); end
    checks++; if (num_q.size() !== 4) begin errors++; $display("FAIL basic_div_beats got=%0d want=4", num_q.size()); end
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (i >= num_q.size() || num_q[i] !== vec[i] || den_q[i] !== 16'h0A00) begin
        errors++; $display("FAIL basic_div[%0d] got=%h/%h want=%h/0a00", i, (i < num_q.size()) ? num_q[i] : 16'hxxxx, (i < den_q.size()) ? den_q[i] : 16'hxxxx, vec[i]);
      end
    end
    checks++; if (done_cnt !== 1) begin errors++; $display("FAIL basic_done_count got=%0d want=1", done_cnt); end
    checks++; if (clear_cnt !== 1) begin errors++; $display("FAIL basic_clear_count got=%0d want=1", clear_cnt); end
  endtask

  task automatic test_backpressure();
    bit to;
    logic [15:0] s;
    clear_stats();
    for (int i = 0; i < 3; i++) vec[i] = 16'($urandom);
    s = model_sum(3);
    sum_delay = 2;
    run_vector(3, 1'b0, 1, 5, 1'b0, to);
    checks++; if (to) begin errors++; $display("FAIL bp_timeout got=timeout want=done"); end
    checks++; if (stall_err !== 0) begin errors++; $display("FAIL bp_hold_stable got=%0d want=0 unstable cycles", stall_err); end
    checks++; if (stall_cyc !== 5) begin errors++; $display("FAIL bp_stall_cycles got=%0d want=5", stall_cyc); end
    checks++; if (num_q.size() !== 3) begin errors++; $display("FAIL bp_div_beats got=%0d want=3", num_q.size()); end
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (i >= num_q.size() || num_q[i] !== vec[i] || den_q[i] !== s) begin
        errors++; $display("FAIL bp_div[%0d] got=%h/%h want=%h/%h", i, (i < num_q.size()) ? num_q[i] : 16'hxxxx, (i < den_q.size()) ? den_q[i] : 16'hxxxx, vec[i], s);
      end
    end
    checks++; if (div_at_done !== 3) begin errors++; $display("FAIL bp_done_after_last got=%0d want=3 beats before done", div_at_done); end
    checks++; if (done_cnt !== 1) begin errors++; $display("FAIL bp_done_count got=%0d want=1", done_cnt); end
  endtask

  task automatic test_illegal();
    int lens [2] = '{0, 65};
    int s;
    for (int k = 0; k < 2; k++) begin
      clear_stats();
      bus.start_i = 1'b1;
      bus.len_i   = LEN_W'(lens[k]);
      @(negedge clock_i);
      s = cyc;
      @(posedge clock_i); #1;
      bus.start_i = 1'b0;
      repeat (4) @(posedge clock_i);
      #1;
      $display("illegal start len=%0d err_pulses=%0d", lens[k], err_cnt);
      checks++; if (err_cnt !== 1) begin errors++; $display("FAIL illegal_err_count len=%0d got=%0d want=1", lens[k], err_cnt); end
      checks++; if (err_cyc !== s + 1) begin errors++; $display("FAIL illegal_err_timing len=%0d got=%0d want=%0d", lens[k], err_cyc - s, 1); end
      checks++; if (busy_cnt !== 0) begin errors++; $display("FAIL illegal_busy len=%0d got=%0d want=0", lens[k], busy_cnt); end
      checks++; if (clear_cnt !== 0) begin errors++; $display("FAIL illegal_clear len=%0d got=%0d want=0", lens[k], clear_cnt); end
    end
  endtask

  task automatic test_full_len();
    bit to;
    int bad_add = 0, bad_div = 0;
    logic [15:0] s;
    clear_stats();
    for (int i = 0; i < MAX_LEN; i++) vec[i] = 16'($urandom);
    s = model_sum(MAX_LEN);
    sum_delay = 1;
    run_vector(MAX_LEN, 1'b1, -1, 0, 1'b0, to);
    checks++; if (to) begin errors++; $display("FAIL full_timeout got=timeout want=done"); end
    checks++; if (adder_q.size() !== MAX_LEN) begin errors++; $display("FAIL full_adder_beats got=%0d want=%0d", adder_q.size(), MAX_LEN); end
    checks++; if (num_q.size() !== MAX_LEN) begin errors++; $display("FAIL full_div_beats got=%0d want=%0d", num_q.size(), MAX_LEN); end
    for (int i = 0; i < MAX_LEN && i < adder_q.size() && i < num_q.size(); i++) begin
      if (adder_q[i] !== vec[i]) bad_add++;
      if (num_q[i] !== vec[i] || den_q[i] !== s) bad_div++;
    end
    checks++; if (bad_add !== 0) begin errors++; $display("FAIL full_adder_order got=%0d want=0 wrong beats", bad_add); end
    checks++; if (bad_div !== 0) begin errors++; $display("FAIL full_readback got=%0d want=0 wrong beats", bad_div); end
    checks++; if (exp_done_cyc !== last_acc_cyc + 2) begin errors++; $display("FAIL full_exp_done_latency got=%0d want=2", exp_done_cyc - last_acc_cyc); end
    checks++; if (done_cnt !== 1) begin errors++; $display("FAIL full_done_count got=%0d want=1", done_cnt); end
  endtask

  task automatic test_ignored();
    bit to;
    logic [15:0] s;
    clear_stats();
    for (int i = 0; i < 4; i++) vec[i] = 16'($urandom);
    s = model_sum(4);
    sum_delay = 6;
    run_vector(4, 1'b0, 0, 5, 1'b1, to);
    repeat (3) @(posedge clock_i);
    @(negedge clock_i);
    checks++; if (to) begin errors++; $display("FAIL ign_timeout got=timeout want=done"); end
    checks++; if (adder_q.size() !== 4) begin errors++; $display("FAIL ign_adder_beats got=%0d want=4", adder_q.size()); end
    checks++; if (den_q.size() !== 4 || den_q[0] !== s) begin errors++; $display("FAIL ign_sum got=%h want=%h", (den_q.size() > 0) ? den_q[0] : 16'hxxxx, s); end
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (i >= num_q.size() || num_q[i] !== vec[i]) begin
        errors++; $display("FAIL ign_div_num[%0d] got=%h want=%h", i, (i < num_q.size()) ? num_q[i] : 16'hxxxx, vec[i]);
      end
    end
    checks++; if (done_cnt !== 1) begin errors++; $display("FAIL ign_done_count got=%0d want=1", done_cnt); end
    checks++; if (clear_cnt !== 1) begin errors++; $display("FAIL ign_restart got=%0d clears want=1", clear_cnt); end
    checks++; if (bus.busy_o !== 1'b0) begin errors++; $display("FAIL ign_idle_after got=%b want=0", bus.busy_o); end
    @(posedge clock_i); #1;
  endtask

  task automatic test_reset_mid();
    bit to;
    int idx = 0, n = 0;
    logic [15:0] s;
    clear_stats();
    for (int i = 0; i < 5; i++) vec[i] = 16'($urandom);
    sum_delay = 0;
    bus.start_i = 1'b1;
    bus.len_i   = LEN_W'(5);
    @(posedge clock_i); #1;
    bus.start_i = 1'b0;
    while (idx < 2 && n < BUDGET) begin
      bus.exp_valid_i = 1'b1;
      bus.exp_data_i  = vec[idx];
      @(negedge clock_i);
      if (bus.exp_valid_i && bus.exp_ready_o) idx++;
      @(posedge clock_i); #1;
      n++;
    end
    bus.exp_valid_i = 1'b0;
    reset_i = 1'b1;
    @(posedge clock_i);
    @(negedge clock_i);
    $display("reset mid-vector after %0d beats", idx);
    checks++; if (idx !== 2) begin errors++; $display("FAIL rst_feed got=%0d want=2 beats", idx); end
    checks++; if (all_outputs() !== '0) begin errors++; $display("FAIL rst_outputs got=%h want=0", all_outputs()); end
    checks++; if (adder_q.size() !== 2) begin errors++; $display("FAIL rst_adder_beats got=%0d want=2", adder_q.size()); end
    checks++; if (done_cnt !== 0 || exp_done_cnt !== 0) begin errors++; $display("FAIL rst_no_done got=%0d/%0d want=0/0", done_cnt, exp_done_cnt); end
    @(posedge clock_i); #1;
    reset_i = 1'b0;
    @(posedge clock_i); #1;
    clear_stats();
    vec[0] = 16'($urandom);
    vec[1] = 16'($urandom);
    s = model_sum(2);
    run_vector(2, 1'b0, -1, 0, 1'b0, to);
    checks++; if (to) begin errors++; $display("FAIL rst_fresh_timeout got=timeout want=done"); end
    checks++; if (num_q.size() !== 2 || num_q[0] !== vec[0] || num_q[1] !== vec[1]) begin
      errors++; $display("FAIL rst_fresh_nums got=%0d beats want=2 matching", num_q.size());
    end
    checks++; if (den_q.size() !== 2 || den_q[1] !== s) begin errors++; $display("FAIL rst_fresh_sum got=%h want=%h", (den_q.size() > 1) ? den_q[1] : 16'hxxxx, s); end
    checks++; if (done_cnt !== 1) begin errors++; $display("FAIL rst_fresh_done got=%0d want=1", done_cnt); end
  endtask

  initial begin
    bus.start_i     = 1'b0;
    bus.len_i       = '0;
    bus.exp_data_i  = '0;
    bus.exp_valid_i = 1'b0;
    bus.div_ready_i = 1'b0;
    sum_delay       = 0;
    clear_stats();
    test_reset();
    test_basic();
    test_backpressure();
    test_illegal();
    test_full_len();
    test_ignored();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/softmax_sum_ctrl_16.md
Name: softmax_sum_ctrl_16

Overview:
- Sequences one softmax vector through the 16-bit exponent-sum adder and the downstream divider.
- Accepts exp values from the exp unit, forwards each one to the adder, and keeps a copy in a local buffer.
- Counts beats against the programmed vector length, then signals exp-done and waits for the adder sum.
- Replays the buffered values paired with the latched sum to the divider as numerator/denominator beats.

Parameters:
- DATA_W, 16, data width of exp values, sum and divider operands.
- MAX_LEN, 64, maximum vector length; also the buffer depth.
- LEN_W, 7, width of the length and counters; must be at least clog2(MAX_LEN+1).

Ports:
- clock_i  in  1  single clock, rising edge.
- reset_i  in  1  synchronous, active-high reset.
- start_i  in  1  start one vector; sampled in IDLE only.
- len_i  in  LEN_W  vector length; sampled together with start_i.
- exp_data_i  in  DATA_W  exp value from the exp unit.
- exp_valid_i  in  1  exp_data_i is valid.
- exp_ready_o  out  1  controller accepts an exp beat.
- adder_clear_o  out  1  clears the adder accumulator and its valid flag.
- adder_data_o  out  DATA_W  beat to the adder.
- adder_valid_o  out  1  adder_data_o is valid.
- exp_done_o  out  1  one-cycle pulse: all beats have landed in the adder.
- sum_i  in  DATA_W  adder result.
- sum_valid_i  in  1  adder result is valid; level signal.
- div_num_o  out  DATA_W  numerator (buffered exp value).
- div_den_o  out  DATA_W  denominator (latched sum).
- div_valid_o  out  1  divider beat is valid.
- div_ready_i  in  1  divider accepts a beat.
- busy_o  out  1  controller is not in IDLE.
- done_o  out  1  one-cycle pulse: last divider beat accepted.
- err_o  out  1  one-cycle pulse: illegal len_i at start.

Behaviour:
- Reset values: every output is 0. Reset forces IDLE, clears counters and buffer pointers, and clears the latched sum.
- Reset mid-operation aborts the vector with no done_o pulse.
- IDLE:
  - start_i with 1 <= len_i <= MAX_LEN: latch len_i, go to CLEAR.
  - start_i with len_i = 0 or len_i > MAX_LEN: err_o pulses the next cycle; stay in IDLE.
- CLEAR (exactly one cycle): adder_clear_o = 1, then go to ACCUM.
- ACCUM:
  - exp_ready_o = 1 while in_cnt < len.
  - A beat is accepted when exp_valid_i & exp_ready_o.
  - Each accepted beat is written to buffer[in_cnt] and in_cnt increments.
  - adder_data_o / adder_valid_o are registered copies of the accepted beat, so they appear 1 cycle after acceptance.
  - After the last beat is accepted, go to FLUSH.
- FLUSH (one cycle): lets the last adder beat be accumulated. On exit exp_done_o pulses for one cycle; go to WAIT_SUM.
- WAIT_SUM:
  - Wait for sum_valid_i; then latch sum_i into the denominator register and go to NORM.
  - There is no timeout.
  - A sum_i of 0 is passed through unchanged; divide-by-zero handling belongs to the divider.
- NORM:
  - div_valid_o = 1 with div_num_o = buffer[out_cnt] and div_den_o = the latched sum.
  - Handshake on div_valid_o & div_ready_i; out_cnt increments on each accepted beat.
  - div_num_o/div_den_o are held stable while div_valid_o is high and div_ready_i is low.
  - Once div_valid_o is raised it does not drop until the beat is accepted.
  - After the last beat is accepted, go to DONE.
- DONE (one cycle): done_o = 1, then go to IDLE.
- Latency, start to first exp_ready_o: 2 cycles (start sampled, then CLEAR).
- Last accepted beat to exp_done_o: 2 cycles.
- start_i while busy_o = 1 is ignored, and err_o is not pulsed.
- exp_valid_i outside ACCUM is ignored; exp_ready_o = 0 there.
- Buffer: one write port (ACCUM) and one read port (NORM), never active together. Pointers reset per vector and do not wrap within a vector.
- Adder contract: the adder extension must honour adder_clear_o as a synchronous clear of both its accumulator and its valid flag.
- Widths: in_cnt and out_cnt are LEN_W bits. Comparisons against len are unsigned.

Decomposition:
- Shared package holds:
  - the state encoding: IDLE=0, CLEAR=1, ACCUM=2, FLUSH=3, WAIT_SUM=4, NORM=5, DONE=6;
  - DATA_W and MAX_LEN defaults.
- One sub-module: softmax_vec_buf, a simple dual-port register buffer (MAX_LEN x DATA_W) with synchronous write and combinational read.
- FSM, counters and handshakes live in the top module.

Test Plan:
- Basic vector: start with len_i=4, stream 0x0100, 0x0200, 0x0300, 0x0400 back-to-back, model adder returns 0x0A00 → adder sees 4 beats; exp_done_o pulses exactly once, 2 cycles after the 4th acceptance; divider sees num 0x0100..0x0400 with den 0x0A00; done_o pulses once.
- Divider backpressure: len_i=3, div_ready_i low for 5 cycles on beat 2 → num/den held stable; no beat dropped or duplicated; done_o only after the 3rd accept.
- Illegal length: len_i=0, then len_i=65 → err_o pulses each time; busy_o stays 0; adder_clear_o never asserts.
- Full length with gaps: len_i=64, exp_valid_i toggling every other cycle → exactly 64 adder beats; buffer readback matches the input order.
- Ignored inputs: start_i asserted during NORM, and exp_valid_i asserted during WAIT_SUM → both ignored; the current vector completes normally.
- Reset mid-vector: reset_i in ACCUM after 2 of 5 beats → all outputs 0 the next cycle; a fresh len_i=2 vector then completes with a correct sum and done_o.
